note_lane_draw_ctrl: RTL and testbench
======================================

// Module: note_lane_draw_ctrl
// PURPOSE
//  Sequences one redraw of the note lane: 10 squares, each SQ_SIZE x SQ_SIZE pixels, in one row.
//  Each frame is an erase pass (all squares black) followed by a draw pass (red/yellow/black per square).
//  Drives the VGA adapter pixel port (x, y, colour, plot), one pixel per clock.
//  Triggered by the beat/frame tick from the game controller; reports busy/done back to it.
// PARAMETERS
//  NUM_SQ   10   squares per lane; also the width of red_sequence and yellow_sequence
//  SQ_SIZE  4    square edge in pixels; must be a power of 2
//  X_START  10   x of the left column of square 0
//  X_STEP   10   x pitch between squares; must be >= SQ_SIZE
//  Y_ROW    112  y of the top row of every square
// PORTS
//  clk              in   1       system clock
//  resetn           in   1       asynchronous, active-low reset
//  start            in   1       request one full frame; sampled only in IDLE
//  red_sequence     in   NUM_SQ  bit i = square i is a red note
//  yellow_sequence  in   NUM_SQ  bit i = square i is a yellow note
//  busy             out  1       high in every state except IDLE
//  done             out  1       1-cycle pulse when the frame completes
//  x                out  8       pixel x (registered)
//  y                out  7       pixel y (registered)
//  colour           out  3       pixel colour {R,G,B} (registered)
//  plot             out  1       pixel write enable (registered)
// BEHAVIOUR
//  Reset: state=IDLE; x=0, y=0, colour=BLACK, plot=0, busy=0, done=0; counters and snapshots = 0. Takes effect immediately.
//  States:
//   IDLE:  start=1 -> ERASE. Both sequences are latched into snapshot registers on that edge.
//   ERASE: walks all NUM_SQ squares; after the last pixel of the last square -> DRAW.
//   DRAW:  walks all NUM_SQ squares again; after the last pixel of the last square -> DONE.
//   DONE:  one cycle with done=1 -> IDLE.
//  Pixel walk:
//   Column counter px is the inner loop, row counter py the middle loop, square index sq the outer loop.
//   x = X_START + sq*X_STEP + px; y = Y_ROW + py.
//   Compute at full width, then truncate to 8 bits (x) and 7 bits (y).
//  Colour:
//   ERASE: BLACK.
//   DRAW: red_snap[sq] -> RED 3'b100; else yellow_snap[sq] -> YELLOW 3'b110; else BLACK. Red wins when both are set.
//   The draw pass never holds a previous colour.
//  Timing:
//   Outputs are registered, one pixel per cycle, with no gaps.
//   start is seen at edge 0. The first plot is visible after edge 1.
//   There are exactly 2*NUM_SQ*SQ_SIZE^2 plot cycles; with defaults that is 320, on cycles 1..320.
//   done=1 on cycle 321; busy=0 again on cycle 322.
//   plot=0 in IDLE and DONE.
//  Boundaries:
//   start while busy (including in DONE) is ignored; no queuing.
//   start held high re-triggers from IDLE; the next frame's first plot is on cycle 323.
//   Sequence inputs that change mid-frame have no effect; the snapshot is used.
//   resetn deasserting mid-frame abandons the frame with no done pulse; the lane is partially drawn.
//  Counters wrap to 0 at SQ_SIZE-1 / NUM_SQ-1. The wrap carries into the next loop level.
// STRUCTURE
//  Shared package draw_pkg:
//   colour localparams BLACK, RED, YELLOW, GREEN, BLUE;
//   state encodings IDLE, ERASE, DRAW, DONE;
//   lane geometry defaults (X_START, X_STEP, Y_ROW).
//  Sub-module square_pixel_walker (sequential):
//   inputs clk, resetn, clear, advance;
//   outputs sq, px, py, last_pixel, last_square.
//  Top level holds the FSM, the snapshot registers, the colour select and the output registers.
// TESTING
//  1. Reset: hold resetn=0 -> plot=0, busy=0, done=0, x=0, y=0, colour=0.
//     Release with start=0 -> nothing changes for 50 cycles.
//  2. Single frame, red=10'b0000000001, yellow=10'b0000000010:
//     - 160 black plots covering x 10..103, y 112..115;
//     - then sq0 RED at x 10..13, sq1 YELLOW at x 20..23, sq2..9 BLACK;
//     - done on cycle 321, exactly 320 plot cycles in total.
//  3. Priority: red=yellow=10'h3FF -> every draw-pass pixel is 3'b100.
//  4. Snapshot and ignore: toggle the sequences and pulse start at cycle 100 ->
//     pixels still match the latched values; done pulses once; total plots = 320.
//  5. Reset mid-frame: resetn=0 at cycle 50 -> plot=0 and busy=0 at once; no done.
//     A new start afterwards gives a full 320-plot frame.
//  6. start held high for 700 cycles -> done on cycles 321 and 643; no plot in IDLE/DONE cycles.

Source files
------------

// File: rtl/draw_pkg.sv
// ---------------------------------------------------------------------------
// draw_pkg
// Shared definitions for the note-lane drawing logic.
//   - 3-bit {R,G,B} colour codes used on the VGA adapter pixel port
//   - FSM state encoding for the lane redraw sequencer
//   - default lane geometry (left column, pitch, top row)
//   - cnt_w(): counter width for a modulo-n counter (never below 1 bit)
// ---------------------------------------------------------------------------
package draw_pkg;

  localparam logic [2:0] BLACK  = 3'b000;
  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b110;
  localparam logic [2:0] GREEN  = 3'b010;
  localparam logic [2:0] BLUE   = 3'b001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ERASE = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int LANE_X_START = 10;
  localparam int LANE_X_STEP  = 10;
  localparam int LANE_Y_ROW   = 112;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/square_pixel_walker.sv
// ---------------------------------------------------------------------------
// square_pixel_walker
// Three nested wrap-around counters that visit every pixel of every square:
// px (column, innermost), py (row), sq (square index, outermost).
// Ports:
//   clk, resetn      clock, asynchronous active-low reset
//   clear            force all counters to 0 (wins over advance)
//   advance          step to the next pixel; wraps carry outward
//   sq, px, py       current square index / column / row
//   last_pixel       current pixel is the bottom-right one of its square
//   last_square      current square is the last one in the lane
// ---------------------------------------------------------------------------
module square_pixel_walker
  import draw_pkg::*;
#(
  parameter int NUM_SQ  = 10,
  parameter int SQ_SIZE = 4,
  localparam int SW = cnt_w(NUM_SQ),
  localparam int PW = cnt_w(SQ_SIZE)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clear,
  input  logic          advance,
  output logic [SW-1:0] sq,
  output logic [PW-1:0] px,
  output logic [PW-1:0] py,
  output logic          last_pixel,
  output logic          last_square
);

  logic [SW-1:0] sq_q, sq_d;
  logic [PW-1:0] px_q, px_d;
  logic [PW-1:0] py_q, py_d;
  logic          px_last, py_last, sq_last;

  assign px_last = (px_q == PW'(SQ_SIZE - 1));
  assign py_last = (py_q == PW'(SQ_SIZE - 1));
  assign sq_last = (sq_q == SW'(NUM_SQ - 1));

  always_comb begin
    sq_d = sq_q;
    px_d = px_q;
    py_d = py_q;
    if (clear) begin
      sq_d = '0;
      px_d = '0;
      py_d = '0;
    end else if (advance) begin
      if (px_last) begin
        px_d = '0;
        if (py_last) begin
          py_d = '0;
          sq_d = sq_last ? '0 : sq_q + 1'b1;
        end else begin
          py_d = py_q + 1'b1;
        end
      end else begin
        px_d = px_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sq_q <= '0;
      px_q <= '0;
      py_q <= '0;
    end else begin
      sq_q <= sq_d;
      px_q <= px_d;
      py_q <= py_d;
    end
  end

  assign sq          = sq_q;
  assign px          = px_q;
  assign py          = py_q;
  assign last_pixel  = px_last & py_last;
  assign last_square = sq_last;

endmodule

// File: rtl/note_lane_draw_ctrl.sv
// ---------------------------------------------------------------------------
// note_lane_draw_ctrl
// Redraws one row of NUM_SQ notes: an erase pass (all black) then a draw
// pass (red / yellow / black per square), one pixel per clock, no gaps.
// Ports:
//   clk, resetn                       clock, asynchronous active-low reset
//   start                             request a frame (only honoured in IDLE)
//   red_sequence, yellow_sequence     per-square note flags, latched at start
//   busy, done                        status back to the game controller
//   x, y, colour, plot                registered VGA adapter pixel port
// All outputs are registered from the state being executed, so they trail
// the FSM by one cycle: the DONE state shows up as done=1 one cycle later,
// and busy drops the cycle after that.
// ---------------------------------------------------------------------------
module note_lane_draw_ctrl
  import draw_pkg::*;
#(
  parameter int NUM_SQ  = 10,
  parameter int SQ_SIZE = 4,
  parameter int X_START = LANE_X_START,
  parameter int X_STEP  = LANE_X_STEP,
  parameter int Y_ROW   = LANE_Y_ROW
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [NUM_SQ-1:0] red_sequence,
  input  logic [NUM_SQ-1:0] yellow_sequence,
  output logic              busy,
  output logic              done,
  output logic [7:0]        x,
  output logic [6:0]        y,
  output logic [2:0]        colour,
  output logic              plot
);

  localparam int SW = cnt_w(NUM_SQ);
  localparam int PW = cnt_w(SQ_SIZE);

  state_e            state_q;
  logic [NUM_SQ-1:0] red_snap_q, yellow_snap_q;
  logic              busy_q, done_q, plot_q;
  logic [7:0]        x_q;
  logic [6:0]        y_q;
  logic [2:0]        colour_q;

  logic [SW-1:0]     sq;
  logic [PW-1:0]     px, py;
  logic              last_pixel, last_square;
  logic              walking;
  logic [7:0]        x_pix;
  logic [6:0]        y_pix;
  logic [2:0]        colour_pix;

  assign walking = (state_q == ERASE) || (state_q == DRAW);

  // Counters sit at 0 while idle so every pass starts at square 0, pixel 0;
  // at the end of a pass they wrap to 0 on their own.
  square_pixel_walker #(
    .NUM_SQ  (NUM_SQ),
    .SQ_SIZE (SQ_SIZE)
  ) u_walker (
    .clk         (clk),
    .resetn      (resetn),
    .clear       (state_q == IDLE),
    .advance     (walking),
    .sq          (sq),
    .px          (px),
    .py          (py),
    .last_pixel  (last_pixel),
    .last_square (last_square)
  );

  // Full-width arithmetic, then truncate to the adapter's coordinate widths.
  assign x_pix = 8'(X_START + int'(sq) * X_STEP + int'(px));
  assign y_pix = 7'(Y_ROW + int'(py));

  always_comb begin
    colour_pix = BLACK;
    if (state_q == DRAW) begin
      if (red_snap_q[sq])         colour_pix = RED;
      else if (yellow_snap_q[sq]) colour_pix = YELLOW;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      red_snap_q    <= '0;
      yellow_snap_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      plot_q        <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      colour_q      <= BLACK;
    end else begin
      busy_q <= (state_q != IDLE);
      done_q <= (state_q == DONE);
      plot_q <= walking;
      // Pixel registers hold their last value whenever nothing is plotted.
      if (walking) begin
        x_q      <= x_pix;
        y_q      <= y_pix;
        colour_q <= colour_pix;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            red_snap_q    <= red_sequence;
            yellow_snap_q <= yellow_sequence;
            state_q       <= ERASE;
          end
        end
        ERASE: if (last_pixel && last_square) state_q <= DRAW;
        DRAW:  if (last_pixel && last_square) state_q <= DONE;
        DONE:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign plot   = plot_q;
  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;

endmodule

// File: tb/tb_note_lane_draw_ctrl.sv
// ---------------------------------------------------------------------------
// Self-checking bench for note_lane_draw_ctrl. A reference model accepts
// frames at the clock edges where start is high and the lane is idle and
// queues every expected pixel (with its cycle) and the expected done cycle.
// A negedge monitor pops and compares whenever plot or done is seen.
// ---------------------------------------------------------------------------
module tb_note_lane_draw_ctrl;

  localparam int NSQ   = 10;
  localparam int SQS   = 4;
  localparam int PLOTS = 2 * NSQ * SQS * SQS;   // 320

  typedef struct {
    int cyc;
    int px;
    int py;
    int col;
  } pix_t;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic           start = 1'b0;
  logic [NSQ-1:0] red_sequence = '0;
  logic [NSQ-1:0] yellow_sequence = '0;
  logic           busy, done, plot;
  logic [7:0]     x;
  logic [6:0]     y;
  logic [2:0]     colour;

  note_lane_draw_ctrl dut (
    .clk             (clk),
    .resetn          (resetn),
    .start           (start),
    .red_sequence    (red_sequence),
    .yellow_sequence (yellow_sequence),
    .busy            (busy),
    .done            (done),
    .x               (x),
    .y               (y),
    .colour          (colour),
    .plot            (plot)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;            // number of rising edges seen so far
  int   idle_from = 0;      // first edge at which the model accepts start
  int   b_lo = 0;
  int   b_hi = -1;          // model busy window [b_lo, b_hi]
  pix_t exp_q[$];
  int   exp_done_q[$];
  int   plot_cnt = 0;
  int   done_cnt = 0;
  int   done_seen[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: frame accepted at edge e, plots on cycles e+1..e+320.
  task automatic push_frame(input int e, input logic [NSQ-1:0] r, input logic [NSQ-1:0] yl);
    int k;
    pix_t p;
    k = 0;
    for (int pass = 0; pass < 2; pass++)
      for (int s = 0; s < NSQ; s++)
        for (int j = 0; j < SQS; j++)
          for (int i = 0; i < SQS; i++) begin
            k++;
            p.cyc = e + k;
            p.px  = (10 + s * 10 + i) % 256;
            p.py  = (112 + j) % 128;
            if (pass == 0)  p.col = 0;
            else if (r[s])  p.col = 4;
            else if (yl[s]) p.col = 6;
            else            p.col = 0;
            exp_q.push_back(p);
          end
    exp_done_q.push_back(e + PLOTS + 1);
  endtask

  always @(posedge clk) begin
    if (!resetn) begin
      exp_q.delete();
      exp_done_q.delete();
      idle_from <= 0;
      b_hi      <= -1;
    end else if (start && (cyc + 1) >= idle_from) begin
      push_frame(cyc + 1, red_sequence, yellow_sequence);
      idle_from <= cyc + 1 + PLOTS + 2;
      b_lo      <= cyc + 2;
      b_hi      <= cyc + 1 + PLOTS + 1;
    end
    cyc <= cyc + 1;
  end

  // Monitor
  always @(negedge clk) begin
    pix_t p;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      n_checks++;
      $display("FAIL plot_missing: got no plot expected plot at cycle %0d", exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    while (exp_done_q.size() > 0 && exp_done_q[0] < cyc) begin
      n_checks++;
      $display("FAIL done_missing: got no done expected done at cycle %0d", exp_done_q[0]);
      void'(exp_done_q.pop_front());
    end
    if (plot) begin
      plot_cnt++;
      n_checks++;
      if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
        $display("FAIL plot_unexpected: got plot at cycle %0d expected none", cyc);
      end else begin
        p = exp_q.pop_front();
        if (int'(x) == p.px && int'(y) == p.py && int'(colour) == p.col) n_pass++;
        else $display("FAIL pixel: got x=%0d y=%0d c=%0d expected x=%0d y=%0d c=%0d (cycle %0d)",
                      x, y, colour, p.px, p.py, p.col, cyc);
      end
    end
    if (done) begin
      done_cnt++;
      done_seen.push_back(cyc);
      n_checks++;
      if (exp_done_q.size() > 0 && exp_done_q[0] == cyc) begin
        n_pass++;
        void'(exp_done_q.pop_front());
      end else begin
        $display("FAIL done_unexpected: got done at cycle %0d expected none", cyc);
      end
    end
    check("busy", int'(busy), (cyc >= b_lo && cyc <= b_hi) ? 1 : 0);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic pulse_start(output int e);
    e = cyc + 1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    int e, pc, dc;
    // 1. Reset
    tick(3);
    check("rst_plot", int'(plot), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_x", int'(x), 0);
    check("rst_y", int'(y), 0);
    check("rst_colour", int'(colour), 0);
    resetn = 1'b1;
    tick(50);
    check("idle_x", int'(x), 0);
    check("idle_y", int'(y), 0);
    check("idle_colour", int'(colour), 0);
    check("idle_done_cnt", done_cnt, 0);

    // 2. Single frame
    red_sequence = 10'b0000000001;
    yellow_sequence = 10'b0000000010;
    pc = plot_cnt;
    pulse_start(e);
    tick(PLOTS + 10);
    check("frame_plots", plot_cnt - pc, PLOTS);
    check("frame_done_cycle", done_seen[done_seen.size() - 1] - e, PLOTS + 1);

    // 3. Red priority
    red_sequence = '1;
    yellow_sequence = '1;
    pc = plot_cnt;
    pulse_start(e);
    tick(PLOTS + 10);
    check("prio_plots", plot_cnt - pc, PLOTS);

    // 4. Snapshot and ignored start
    red_sequence = NSQ'($urandom);
    yellow_sequence = NSQ'($urandom);
    pc = plot_cnt;
    dc = done_cnt;
    pulse_start(e);
    tick(e + 100 - cyc);
    red_sequence = ~red_sequence;
    yellow_sequence = ~yellow_sequence;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(PLOTS);
    check("snap_plots", plot_cnt - pc, PLOTS);
    check("snap_dones", done_cnt - dc, 1);

    // 5. Reset mid-frame
    red_sequence = NSQ'($urandom);
    yellow_sequence = NSQ'($urandom);
    dc = done_cnt;
    pulse_start(e);
    tick(e + 50 - cyc);
    resetn = 1'b0;
    #1;
    check("midrst_plot", int'(plot), 0);
    check("midrst_busy", int'(busy), 0);
    tick(2);
    resetn = 1'b1;
    tick(10);
    check("midrst_no_done", done_cnt - dc, 0);
    pc = plot_cnt;
    pulse_start(e);
    tick(PLOTS + 10);
    check("after_rst_plots", plot_cnt - pc, PLOTS);

    // 6. start held high: re-triggers from IDLE every 322 cycles
    dc = done_cnt;
    e = cyc + 1;
    start = 1'b1;
    for (int i = 0; i < 700; i++) begin
      if ((i % 37) == 0) begin
        red_sequence = NSQ'($urandom);
        yellow_sequence = NSQ'($urandom);
      end
      tick(1);
    end
    start = 1'b0;
    tick(PLOTS + 20);
    check("held_done1", done_seen[dc] - e, 321);
    check("held_done2", done_seen[dc + 1] - e, 643);

    check("leftover_pixels", exp_q.size(), 0);
    check("leftover_dones", exp_done_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
